pixel_stream_reader: RTL and testbench

//  Frame-buffer reader that produces the raster pixel stream consumed by the convolution filter.
//  On a start pulse it reads one ROW_SIZE x NUM_ROWS frame from a synchronous-read memory.
//  It emits one pixel per clock in raster order, then emits FLUSH_LEN pad pixels.
//  The pad pixels drain the filter's line buffer and 3-stage arithmetic pipeline.
//  It sits between the frame memory and the convolution block's inputPixel port.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/raster_counter.sv | 52 +++++
 rtl/pixel_stream_reader.sv | 155 +++++++++++++++
 tb/tb_pixel_stream_reader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the frame reader and the convolution block it feeds.
package conv_pkg;

  localparam int unsigned DEF_WORD_SIZE = 8;
  localparam int unsigned DEF_ROW_SIZE  = 540;
  localparam int unsigned DEF_NUM_ROWS  = 540;
  // Arithmetic pipeline depth of the convolution block.
  localparam int unsigned CONV_PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } rd_state_t;

  // $clog2 that never yields a zero-width vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counter with a linear address that advances in lock-step.
module raster_counter
  import conv_pkg::*;
#(
  parameter int unsigned ROW_SIZE = DEF_ROW_SIZE,
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter int unsigned ADDR_W   = clog2_min1(ROW_SIZE * NUM_ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_pixel
);

  localparam int unsigned COL_W = clog2_min1(ROW_SIZE);
  localparam int unsigned ROW_W = clog2_min1(NUM_ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;

  assign last_col   = (col_q == COL_LAST);
  assign last_pixel = last_col && (row_q == ROW_LAST);
  assign addr       = addr_q;

  // Advance col/row/addr together; clear wins over enable. Caller stops on last_pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (clear) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (en) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
      addr_q <= addr_q + 1'b1;
    end
  end

endmodule

// File: rtl/pixel_stream_reader.sv
// Reads one frame from synchronous-read memory and streams it in raster order,
// followed by pad pixels that drain the downstream convolution filter.
module pixel_stream_reader
  import conv_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned          ROW_SIZE  = DEF_ROW_SIZE,
  parameter int unsigned          NUM_ROWS  = DEF_NUM_ROWS,
  parameter logic [WORD_SIZE-1:0] PAD_VALUE = '0,
  parameter int unsigned          FLUSH_LEN = 2 * ROW_SIZE + 2 + CONV_PIPE_LAT,
  parameter int unsigned          ADDR_W    = clog2_min1(ROW_SIZE * NUM_ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic                 pixel_valid,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 busy,
  output logic                 done
);

  // Shared by DRAIN (counts to 1) and FLUSH (counts to FLUSH_LEN-1).
  localparam int unsigned      CNT_W     = clog2_min1(FLUSH_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(1);

  rd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ctr_clear, ctr_en;
  logic             last_col, last_pixel;
  logic             col0_q;
  logic             rd_active;

  logic                 s1_valid_q, s1_line_q, s1_frame_q;
  logic [WORD_SIZE-1:0] pix_q;
  logic                 pix_valid_q, line_q, frame_q;

  raster_counter #(
    .ROW_SIZE (ROW_SIZE),
    .NUM_ROWS (NUM_ROWS),
    .ADDR_W   (ADDR_W)
  ) u_raster_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (ctr_clear),
    .en         (ctr_en),
    .addr       (mem_addr),
    .last_col   (last_col),
    .last_pixel (last_pixel)
  );

  assign rd_active   = (state_q == READ);
  assign mem_rd_en   = rd_active;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign outputPixel = pix_q;
  assign pixel_valid = pix_valid_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

  // Next-state logic for the frame sequencer and its phase counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    ctr_clear = 1'b0;
    ctr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          ctr_clear = 1'b1;
        end
      end
      READ: begin
        if (last_pixel) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          ctr_en = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_END) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, phase counter and registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Tracks whether the address currently issued is column 0 of its row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col0_q <= 1'b1;
    end else if (ctr_clear) begin
      col0_q <= 1'b1;
    end else if (ctr_en) begin
      col0_q <= last_col;
    end
  end

  // Two-stage read pipeline: issue stage, then capture of mem_rdata into the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_line_q   <= 1'b0;
      s1_frame_q  <= 1'b0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      s1_valid_q  <= rd_active;
      s1_line_q   <= rd_active && col0_q;
      s1_frame_q  <= rd_active && (mem_addr == '0);
      pix_q       <= s1_valid_q ? mem_rdata : PAD_VALUE;
      pix_valid_q <= s1_valid_q;
      line_q      <= s1_line_q;
      frame_q     <= s1_frame_q;
    end
  end

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Scoreboard bench for pixel_stream_reader on a 4x3 frame with a 13-beat flush.
module tb_pixel_stream_reader;

  localparam int unsigned R  = 4;
  localparam int unsigned NR = 3;
  localparam int unsigned N  = R * NR;
  localparam int unsigned F  = 13;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata;
  logic [W-1:0]  outputPixel;
  logic          pixel_valid, line_start, frame_start, busy, done;

  pixel_stream_reader #(
    .WORD_SIZE (W),
    .ROW_SIZE  (R),
    .NUM_ROWS  (NR),
    .PAD_VALUE (8'h00),
    .FLUSH_LEN (F),
    .ADDR_W    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .outputPixel (outputPixel),
    .pixel_valid (pixel_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval after the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read frame memory.
  logic [W-1:0] mem [N];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct {int cyc; int addr;} addr_e_t;
  typedef struct {int cyc; logic [W-1:0] pix; logic ls; logic fs;} pix_e_t;

  addr_e_t aq[$];
  pix_e_t  pq[$];
  int      dq[$];
  addr_e_t a_e;
  pix_e_t  p_e;
  int      d_e;

  // Reference model: frame occupancy as plain cycle arithmetic.
  int free_at = 0;
  int busy_lo = 1;
  int busy_hi = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic model_reset();
    aq.delete();
    pq.delete();
    dq.delete();
    free_at = 0;
    busy_lo = 1;
    busy_hi = 0;
  endtask

  // One-cycle start pulse; if the model says the reader is idle, queue the whole frame.
  task automatic pulse_start();
    int c;
    c = cyc;
    start = 1'b1;
    if (!rst && c >= free_at) begin
      for (int i = 0; i < int'(N); i++) begin
        aq.push_back('{cyc: c + 1 + i, addr: i});
        pq.push_back('{cyc: c + 3 + i, pix: mem[i], ls: ((i % R) == 0), fs: (i == 0)});
      end
      dq.push_back(c + N + 3 + F);
      busy_lo = c + 1;
      busy_hi = c + N + 2 + F;
      free_at = c + N + 3 + F;
    end
    step(1);
    start = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", 64'({mem_rd_en, mem_addr, outputPixel, pixel_valid, line_start,
                                frame_start, busy, done}), 64'd0);
    end else begin
      chk("busy", 64'(busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
      if (mem_rd_en) begin
        if (aq.size() == 0) chk("addr_unexpected", 64'(mem_addr), 64'hffff);
        else begin
          a_e = aq.pop_front();
          chk("addr_cycle", 64'(cyc), 64'(a_e.cyc));
          chk("mem_addr", 64'(mem_addr), 64'(a_e.addr));
        end
      end
      if (pixel_valid) begin
        if (pq.size() == 0) chk("pixel_unexpected", 64'(outputPixel), 64'hffff);
        else begin
          p_e = pq.pop_front();
          chk("pixel_cycle", 64'(cyc), 64'(p_e.cyc));
          chk("outputPixel", 64'(outputPixel), 64'(p_e.pix));
          chk("line_start", 64'(line_start), 64'(p_e.ls));
          chk("frame_start", 64'(frame_start), 64'(p_e.fs));
        end
      end else begin
        chk("pad_beat", 64'({outputPixel, line_start, frame_start}), 64'd0);
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", 64'(cyc), 64'hffff);
        else begin
          d_e = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d_e));
        end
      end
    end
  end

  initial begin
    int s;
    for (int i = 0; i < int'(N); i++) mem[i] = W'(i + 1);

    // T1: start toggled while reset is held.
    step(1);
    repeat (3) begin
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(1);
    end
    rst = 1'b0;
    step(2);

    // T2/T3: basic frame, flush and done.
    pulse_start();
    wait_to(free_at + 3);

    // T4: starts mid-READ and mid-FLUSH are ignored.
    s = cyc;
    pulse_start();
    wait_to(s + 6);
    pulse_start();
    wait_to(s + N + 8);
    pulse_start();
    wait_to(free_at);

    // T5: start in the done cycle, twice in a row.
    pulse_start();
    wait_to(free_at);
    pulse_start();
    wait_to(free_at + 2);

    // T6: asynchronous reset between edges while address 5 is issued.
    s = cyc;
    pulse_start();
    wait_to(s + 6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_clear", 64'({mem_rd_en, mem_addr, outputPixel, pixel_valid, line_start,
                                  frame_start, busy, done}), 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);
    pulse_start();
    wait_to(free_at + 2);

    // Randomized frames: random memory contents, gaps and spurious starts.
    for (int k = 0; k < 6; k++) begin
      wait_to(free_at + int'($urandom_range(0, 4)));
      for (int i = 0; i < int'(N); i++) mem[i] = W'($urandom);
      s = cyc;
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        wait_to(s + int'($urandom_range(2, N + F)));
        pulse_start();
      end
    end
    wait_to(free_at + 3);

    chk("addr_queue_empty", 64'(aq.size()), 64'd0);
    chk("pixel_queue_empty", 64'(pq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
